// File: rtl/bcd_preset_editor_if.sv
// Key inputs and preset/edit status outputs of the BCD preset editor.
// The master side drives the raw keys and the slave side drives the preset state.
interface bcd_preset_editor_if;
    logic       BTN_MODE;
    logic       BTN_UP;
    logic       BTN_DOWN;
    logic [7:0] data;
    logic       LOAD;
    logic       EDIT;
    logic       SEL;
    logic [7:0] WORK;

    modport master (
        output BTN_MODE, BTN_UP, BTN_DOWN,
        input  data, LOAD, EDIT, SEL, WORK
    );

    modport slave (
        input  BTN_MODE, BTN_UP, BTN_DOWN,
        output data, LOAD, EDIT, SEL, WORK
    );
endinterface

// File: rtl/bcd_preset_editor.sv
// Debounced three-key editor for a 2-digit BCD preset: edit ones, then tens, then commit
// the working copy to the preset bus with a one-cycle LOAD strobe.
module bcd_preset_editor #(
    parameter int         DB_CYCLES    = 4,
    parameter int         REPEAT_DELAY = 16,
    parameter int         REPEAT_RATE  = 4,
    parameter int         MAX_TENS     = 5,
    parameter logic [7:0] INIT_VALUE   = 8'h59
) (
    input  logic                C_CLK,
    input  logic                RST,
    bcd_preset_editor_if.slave  bus
);
    localparam int CW  = $clog2(DB_CYCLES + 1);
    localparam int RCW = $clog2(REPEAT_DELAY + 1);
    localparam logic [CW-1:0]  DB_LAST    = CW'(DB_CYCLES - 1);
    localparam logic [RCW-1:0] RPT_LAST   = RCW'(REPEAT_DELAY - 1);
    localparam logic [RCW-1:0] RPT_RELOAD = RCW'(REPEAT_DELAY - REPEAT_RATE);
    localparam logic [3:0]     MAX_TENS_D = 4'(MAX_TENS);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_ONES   = 2'd1,
        ST_TENS   = 2'd2,
        ST_COMMIT = 2'd3
    } state_t;

    // Wrap-around digit step; no carry or borrow into the neighbouring digit.
    function automatic logic [3:0] digit_step(input logic [3:0] d, input logic [3:0] max_d,
                                              input logic up);
        logic [3:0] r;
        if (up) begin
            r = (d >= max_d) ? 4'd0 : d + 4'd1;
        end else begin
            r = (d == 4'd0) ? max_d : d - 4'd1;
        end
        return r;
    endfunction

    // Key index 0 = MODE, 1 = UP, 2 = DOWN.
    logic [2:0]         raw_s;
    logic [2:0]         sync1_r;
    logic [2:0]         sync2_r;
    logic [2:0]         lvl_r;
    logic [2:0]         evt_r;
    logic [2:0][CW-1:0] cnt_r;

    state_t             state_r;
    logic [7:0]         work_r;
    logic [7:0]         data_r;
    logic               load_r;
    logic               edit_r;
    logic               sel_r;
    logic               rpt_act_r;
    logic [RCW-1:0]     rpt_cnt_r;

    logic               editing_s;
    logic               mode_evt_s;
    logic               single_s;
    logic               press_s;
    logic               rpt_hold_s;
    logic               rpt_hit_s;
    logic               step_s;
    logic               step_up_s;

    assign raw_s = {bus.BTN_DOWN, bus.BTN_UP, bus.BTN_MODE};

    // Synchronise each key and accept a new level after DB_CYCLES stable differing samples.
    always_ff @(posedge C_CLK) begin
        if (!RST) begin
            sync1_r <= 3'b000;
            sync2_r <= 3'b000;
            lvl_r   <= 3'b000;
            evt_r   <= 3'b000;
            cnt_r   <= '0;
        end else begin
            sync1_r <= raw_s;
            sync2_r <= sync1_r;
            for (int i = 0; i < 3; i++) begin
                if (sync2_r[i] == lvl_r[i]) begin
                    cnt_r[i] <= '0;
                    evt_r[i] <= 1'b0;
                end else if (cnt_r[i] == DB_LAST) begin
                    // Press event is raised on the same edge the level rises.
                    lvl_r[i] <= sync2_r[i];
                    cnt_r[i] <= '0;
                    evt_r[i] <= sync2_r[i];
                end else begin
                    cnt_r[i] <= cnt_r[i] + 1'b1;
                    evt_r[i] <= 1'b0;
                end
            end
        end
    end

    // Decode step requests: MODE wins, and UP/DOWN together never step.
    always_comb begin
        editing_s  = 1'b0;
        mode_evt_s = evt_r[0];
        single_s   = lvl_r[1] ^ lvl_r[2];
        press_s    = 1'b0;
        rpt_hold_s = 1'b0;
        rpt_hit_s  = 1'b0;
        step_up_s  = lvl_r[1];
        if ((state_r == ST_ONES) || (state_r == ST_TENS)) begin
            editing_s = 1'b1;
        end else begin
            editing_s = 1'b0;
        end
        if (editing_s && !mode_evt_s) begin
            press_s    = (evt_r[1] && !lvl_r[2]) || (evt_r[2] && !lvl_r[1]);
            rpt_hold_s = !press_s && rpt_act_r && single_s;
            rpt_hit_s  = rpt_hold_s && (rpt_cnt_r == RPT_LAST);
        end else begin
            press_s    = 1'b0;
            rpt_hold_s = 1'b0;
            rpt_hit_s  = 1'b0;
        end
        step_s = press_s || rpt_hit_s;
    end

    // Auto-repeat timer: armed by a valid press, cleared whenever the hold is broken.
    always_ff @(posedge C_CLK) begin
        if (!RST) begin
            rpt_act_r <= 1'b0;
            rpt_cnt_r <= '0;
        end else if (press_s) begin
            rpt_act_r <= 1'b1;
            rpt_cnt_r <= '0;
        end else if (rpt_hold_s) begin
            rpt_act_r <= 1'b1;
            rpt_cnt_r <= rpt_hit_s ? RPT_RELOAD : rpt_cnt_r + 1'b1;
        end else begin
            rpt_act_r <= 1'b0;
            rpt_cnt_r <= '0;
        end
    end

    // Editor FSM; LOAD/EDIT/SEL are registered from the next state so they align with it.
    always_ff @(posedge C_CLK) begin
        if (!RST) begin
            state_r <= ST_RUN;
            work_r  <= INIT_VALUE;
            data_r  <= INIT_VALUE;
            load_r  <= 1'b0;
            edit_r  <= 1'b0;
            sel_r   <= 1'b0;
        end else begin
            load_r <= 1'b0;
            case (state_r)
                ST_RUN: begin
                    if (mode_evt_s) begin
                        state_r <= ST_ONES;
                        work_r  <= data_r;
                        edit_r  <= 1'b1;
                        sel_r   <= 1'b0;
                    end else begin
                        edit_r <= 1'b0;
                        sel_r  <= 1'b0;
                    end
                end
                ST_ONES: begin
                    if (mode_evt_s) begin
                        state_r <= ST_TENS;
                        edit_r  <= 1'b1;
                        sel_r   <= 1'b1;
                    end else if (step_s) begin
                        work_r <= {work_r[7:4], digit_step(work_r[3:0], 4'd9, step_up_s)};
                    end else begin
                        edit_r <= 1'b1;
                        sel_r  <= 1'b0;
                    end
                end
                ST_TENS: begin
                    if (mode_evt_s) begin
                        state_r <= ST_COMMIT;
                        data_r  <= work_r;
                        load_r  <= 1'b1;
                        edit_r  <= 1'b0;
                        sel_r   <= 1'b0;
                    end else if (step_s) begin
                        work_r <= {digit_step(work_r[7:4], MAX_TENS_D, step_up_s), work_r[3:0]};
                    end else begin
                        edit_r <= 1'b1;
                        sel_r  <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    state_r <= ST_RUN;
                    edit_r  <= 1'b0;
                    sel_r   <= 1'b0;
                end
                default: begin
                    state_r <= ST_RUN;
                    work_r  <= data_r;
                    edit_r  <= 1'b0;
                    sel_r   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data = data_r;
    assign bus.WORK = work_r;
    assign bus.LOAD = load_r;
    assign bus.EDIT = edit_r;
    assign bus.SEL  = sel_r;
endmodule

// File: tb/tb_bcd_preset_editor.sv
// Randomised and directed bench for bcd_preset_editor against a cycle-level behavioural model.
module tb_bcd_preset_editor;
    logic       C_CLK;
    logic       RST;
    logic [2:0] keys;      // 0 = MODE, 1 = UP, 2 = DOWN
    int         n_tests;
    int         n_fail;
    int         cyc;
    int         load_cnt;

    // Behavioural model state
    logic [2:0][5:0] m_hist;
    logic [2:0]      m_lvl;
    logic [2:0]      m_evt;
    int              m_phase;   // 0 run, 1 ones, 2 tens, 3 commit
    int              m_wt, m_wo, m_dt, m_do;
    int              m_since;
    int              m_rkey;
    logic            m_load;

    bcd_preset_editor_if bif ();

    assign bif.BTN_MODE = keys[0];
    assign bif.BTN_UP   = keys[1];
    assign bif.BTN_DOWN = keys[2];

    bcd_preset_editor dut (
        .C_CLK (C_CLK),
        .RST   (RST),
        .bus   (bif.slave)
    );

    initial C_CLK = 1'b0;
    always #5 C_CLK = ~C_CLK;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge of the model, computed from the raw keys present at that edge.
    task automatic model_edge();
        int dir;
        int el;
        cyc++;
        if (!RST) begin
            m_hist  = '0;
            m_lvl   = 3'b000;
            m_evt   = 3'b000;
            m_phase = 0;
            m_wt = 5; m_wo = 9; m_dt = 5; m_do = 9;
            m_since = -1;
            m_load  = 1'b0;
            return;
        end
        m_load = 1'b0;
        case (m_phase)
            0: begin
                m_since = -1;
                if (m_evt[0]) begin
                    m_phase = 1;
                    m_wt = m_dt;
                    m_wo = m_do;
                end
            end
            1, 2: begin
                if (m_evt[0]) begin
                    m_since = -1;
                    if (m_phase == 2) begin
                        m_dt = m_wt; m_do = m_wo; m_load = 1'b1; m_phase = 3;
                    end else begin
                        m_phase = 2;
                    end
                end else begin
                    dir = 0;
                    if (m_evt[1] && !m_lvl[2]) begin
                        dir = 1; m_since = cyc; m_rkey = 1;
                    end else if (m_evt[2] && !m_lvl[1]) begin
                        dir = -1; m_since = cyc; m_rkey = 2;
                    end else if (m_since >= 0 && m_lvl[m_rkey] && !m_lvl[3 - m_rkey]) begin
                        el = cyc - m_since;
                        if (el == 16 || (el > 16 && (el - 16) % 4 == 0))
                            dir = (m_rkey == 1) ? 1 : -1;
                    end else begin
                        m_since = -1;
                    end
                    if (dir != 0) begin
                        if (m_phase == 1) m_wo = (m_wo + dir + 10) % 10;
                        else              m_wt = (m_wt + dir + 6) % 6;
                    end
                end
            end
            default: begin
                m_since = -1;
                m_phase = 0;
            end
        endcase
        // A level flips once the four most recent synchronised samples all disagree with it.
        for (int i = 0; i < 3; i++) begin
            m_hist[i] = {m_hist[i][4:0], keys[i]};
            m_evt[i]  = 1'b0;
            if (!m_lvl[i] && m_hist[i][5:2] == 4'hF) begin
                m_lvl[i] = 1'b1;
                m_evt[i] = 1'b1;
            end else if (m_lvl[i] && m_hist[i][5:2] == 4'h0) begin
                m_lvl[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        logic [31:0] exp;
        logic        m_edit;
        logic        m_sel;
        @(posedge C_CLK);
        model_edge();
        @(negedge C_CLK);
        m_edit = (m_phase == 1) || (m_phase == 2);
        m_sel  = (m_phase == 2);
        exp = 32'(((m_dt * 16 + m_do) * 256 + (m_wt * 16 + m_wo)) * 8)
            | {29'd0, m_load, m_edit, m_sel};
        if (bif.LOAD === 1'b1) load_cnt++;
        check_eq($sformatf("cyc%0d", cyc), {13'd0, bif.data, bif.WORK, bif.LOAD, bif.EDIT, bif.SEL}, exp);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset(input int n);
        RST = 1'b0;
        ticks(n);
        RST = 1'b1;
    endtask

    task automatic press(input int k, input int hold, input int gap);
        keys = 3'b001 << k;
        ticks(hold);
        keys = 3'b000;
        ticks(gap);
    endtask

    initial begin
        int hold;
        int gap;
        n_tests = 0; n_fail = 0; cyc = 0; load_cnt = 0;
        keys = 3'b000;
        RST  = 1'b0;
        m_rkey = 1;

        // Reset values
        do_reset(2);
        check_eq("rst_data", {24'd0, bif.data}, 32'h59);
        check_eq("rst_work", {24'd0, bif.WORK}, 32'h59);
        check_eq("rst_flags", {29'd0, bif.LOAD, bif.EDIT, bif.SEL}, 32'd0);

        // Short glitch on MODE must not register
        keys = 3'b001; ticks(3); keys = 3'b000; ticks(10);
        check_eq("glitch_edit", {31'd0, bif.EDIT}, 32'd0);

        // Edit ones 9->0->1, tens 5->4, commit
        press(0, 6, 8);
        check_eq("enter_edit", {30'd0, bif.EDIT, bif.SEL}, 32'd2);
        press(1, 6, 8);
        press(1, 6, 8);
        check_eq("ones_wrap", {24'd0, bif.WORK}, 32'h51);
        press(0, 6, 8);
        check_eq("sel_tens", {31'd0, bif.SEL}, 32'd1);
        press(2, 6, 8);
        check_eq("tens_down", {24'd0, bif.WORK}, 32'h41);
        check_eq("data_hold", {24'd0, bif.data}, 32'h59);
        load_cnt = 0;
        press(0, 6, 8);
        check_eq("load_once", 32'(load_cnt), 32'd1);
        check_eq("commit_data", {24'd0, bif.data}, 32'h41);
        check_eq("commit_edit", {31'd0, bif.EDIT}, 32'd0);

        // Auto-repeat from ones=0: press step plus seven repeat steps
        do_reset(2);
        press(0, 6, 8);
        press(1, 6, 8);
        check_eq("rpt_start", {24'd0, bif.WORK}, 32'h50);
        press(1, 42, 10);
        check_eq("rpt_ones", {24'd0, bif.WORK}, 32'h58);
        check_eq("rpt_data", {24'd0, bif.data}, 32'h59);

        // UP+DOWN together, then MODE+UP together
        keys = 3'b110; ticks(30); keys = 3'b000; ticks(10);
        check_eq("updown_work", {24'd0, bif.WORK}, 32'h58);
        keys = 3'b011; ticks(6); keys = 3'b000; ticks(8);
        check_eq("modeup_sel", {31'd0, bif.SEL}, 32'd1);
        check_eq("modeup_work", {24'd0, bif.WORK}, 32'h58);

        // Reset in the middle of an edit discards it
        do_reset(2);
        press(0, 6, 8);
        for (int i = 0; i < 3; i++) press(1, 6, 8);
        press(0, 6, 8);
        press(2, 6, 8);
        press(2, 6, 8);
        check_eq("mid_work", {24'd0, bif.WORK}, 32'h32);
        load_cnt = 0;
        do_reset(1);
        check_eq("mid_rst_edit", {31'd0, bif.EDIT}, 32'd0);
        check_eq("mid_rst_data", {24'd0, bif.data}, 32'h59);
        check_eq("mid_rst_work", {24'd0, bif.WORK}, 32'h59);
        ticks(2);
        check_eq("mid_rst_load", 32'(load_cnt), 32'd0);

        // Randomised key traffic, occasionally resetting with keys held
        for (int it = 0; it < 120; it++) begin
            if ($urandom_range(0, 15) == 0) do_reset($urandom_range(1, 2));
            keys = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) keys = 3'b001;
            hold = $urandom_range(1, 45);
            gap  = $urandom_range(0, 12);
            ticks(hold);
            keys = 3'b000;
            ticks(gap);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
